stack_op_sequencer: RTL and testbench
=====================================

// Module: stack_op_sequencer
// PURPOSE
//  Upstream control stage for the stack/TOS datapath block. Accepts one stack command at a time
//  over a valid/ready handshake and expands it into a fixed, multi-cycle sequence of datapath
//  control strobes (mux selects, register enables, memory writes).
//  Tracks stack depth and guards against overflow/underflow.
// PARAMETERS
//  ADDR_WIDTH  12                  TOS / depth width; matches the datapath address width
//  MAX_DEPTH   (1<<ADDR_WIDTH)-1   highest legal depth; slot 0 is never written
// PORTS
//  clk                   in   1   single clock; all logic on posedge
//  reset                 in   1   synchronous, active-low reset; the top level drives the datapath reset as ~reset
//  CMD_VALID             in   1   command present
//  CMD_OP                in   3   000 PUSH_ALU, 001 PUSH_MEM, 010 PUSH_RET, 011 PUSH_ARG, 100 DUP, 101 POP, 110 STORE, 111 SET_TOS
//  CMD_TOS_VALUE         in   AW  new depth for SET_TOS; must equal the datapath MUX_TOS_IN_1 value
//  CMD_READY             out  1   high only in IDLE
//  CMD_DONE              out  1   1-cycle pulse on the last cycle of a sequence
//  CMD_ERR               out  1   1-cycle pulse with CMD_DONE when a command is rejected
//  DEPTH                 out  AW  current stack depth; equals the datapath TOS
//  SEL_MUX_STACK         out  3   to datapath
//  CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM   out 1 each
//  SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT               out 1 each
// BEHAVIOUR
//  - Registered state. All strobes decode from state only (Moore); no input-to-output comb path.
//  - Reset (reset==0 at posedge): state=IDLE, DEPTH=0, every output 0 except CMD_READY=1.
//    Applies mid-sequence as well: the sequence is abandoned with no DONE.
//  - Accept rule: a command is accepted when CMD_VALID && CMD_READY. CMD_OP is latched at accept.
//    READY drops the cycle after accept. The next command is accepted the cycle after DONE.
//  - Sequences (one state per cycle; listed strobes = 1, all others 0):
//      SRD: READ_STACK | MRD: READ_MEM | LOAD: WRITE_STACK, SEL_MUX_STACK=src
//      INC: REG_TOS, UPD=0, DEPTH+1 | DEC: REG_TOS, UPD=1, DEPTH-1 | WR: CTRL_STACK
//      MW0: WRITE_MEM | MW1: MEM_EXT | SET: SEL_MUX_TOS=1, REG_TOS, DEPTH:=CMD_TOS_VALUE
//    Per command:
//      PUSH_ALU/RET/ARG: LOAD(src=op)  -> INC -> WR                      (3 cycles)
//      PUSH_MEM:         MRD -> LOAD(001) -> INC -> WR                   (4 cycles)
//      DUP:              SRD -> LOAD(100) -> INC -> WR                   (4 cycles)
//      POP:              SRD -> DEC; popped value left in the stack read register   (2 cycles)
//      STORE:            MW0 -> MW1 -> DEC                               (3 cycles)
//      SET_TOS:          SET                                             (1 cycle)
//    DONE pulses in the final state; the state returns to IDLE on the next edge.
//  - TOS convention: pre-increment push, so TOS addresses the top element. Depth 0 means empty.
//  - The external-memory address is held stable by upstream from accept until DONE.
//  - SEL_MUX_STACK=000 and SEL_MUX_TOS=0 whenever not otherwise specified.
//  - DEPTH arithmetic is ADDR_WIDTH bits. It never wraps while the guard is compiled in.
// CONFIGURATION
//  STACK_GUARD_EN defined:
//    - A push-class command (PUSH_*, DUP) at DEPTH==MAX_DEPTH is rejected as overflow.
//    - POP, STORE or DUP at DEPTH==0 is rejected as underflow.
//    - A rejected command takes a 1-cycle ERR state: DONE=1, ERR=1, no strobes, DEPTH unchanged.
//    - SET_TOS with CMD_TOS_VALUE>MAX_DEPTH is rejected the same way.
//  STACK_GUARD_EN undefined:
//    - No checks; every command executes; CMD_ERR tied 0.
//    - DEPTH wraps modulo 2^ADDR_WIDTH, matching the datapath TOS.
// STRUCTURE
//  stack_seq_pkg:
//    - opcode localparams (OP_PUSH_ALU..OP_SET_TOS)
//    - state encodings
//    - SEL_MUX_STACK source codes (SRC_ALU=000, SRC_MEM=001, SRC_RET=010, SRC_ARG=011, SRC_TOP=100)
//  Sub-module stack_depth_tracker:
//    - depth register with inc/dec/load
//    - full/empty compare outputs (compare logic under STACK_GUARD_EN)
//  Top: FSM + strobe decode.
// TESTING
//  - Reset, then PUSH_ALU -> READY low 3 cycles; LOAD(SEL=000), INC(UPD=0), WR(CTRL_STACK) in order;
//    DONE in cycle 3; DEPTH=1.
//  - PUSH_ARG x3, POP -> POP shows READ_STACK then DEC(UPD=1); DONE in cycle 2; DEPTH=2.
//  - DEPTH=1, DUP -> SRD, LOAD(SEL=100), INC, WR; DONE in cycle 4; DEPTH=2.
//    STORE -> MW0, MW1, DEC; DEPTH=1.
//  - Guard on, DEPTH=0: POP -> DONE=ERR=1 in cycle 1, no strobes, DEPTH=0.
//    SET_TOS 4095 then PUSH_ALU -> ERR, DEPTH=4095.
//  - Guard off, DEPTH=0: POP -> DEPTH=4095, ERR=0.
//  - Reset low during INC of PUSH_MEM -> next cycle IDLE, DEPTH=0, all strobes 0, no DONE.
//    Back-to-back valid commands -> each accepted exactly one cycle after the previous DONE.

Source files
------------

// File: rtl/stack_op_sequencer_pkg.sv
// Shared opcodes, FSM states, mux source codes and strobe decode
// for the stack command sequencer.
package stack_seq_pkg;

  localparam logic [2:0] OP_PUSH_ALU = 3'b000;
  localparam logic [2:0] OP_PUSH_MEM = 3'b001;
  localparam logic [2:0] OP_PUSH_RET = 3'b010;
  localparam logic [2:0] OP_PUSH_ARG = 3'b011;
  localparam logic [2:0] OP_DUP      = 3'b100;
  localparam logic [2:0] OP_POP      = 3'b101;
  localparam logic [2:0] OP_STORE    = 3'b110;
  localparam logic [2:0] OP_SET_TOS  = 3'b111;

  localparam logic [2:0] SRC_ALU = 3'b000;
  localparam logic [2:0] SRC_MEM = 3'b001;
  localparam logic [2:0] SRC_RET = 3'b010;
  localparam logic [2:0] SRC_ARG = 3'b011;
  localparam logic [2:0] SRC_TOP = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRD,
    ST_MRD,
    ST_LOAD,
    ST_INC,
    ST_DEC,
    ST_WR,
    ST_MW0,
    ST_MW1,
    ST_SET,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [2:0] sel_mux_stack;
    logic       read_stack;
    logic       write_stack;
    logic       read_mem;
    logic       write_mem;
    logic       sel_mux_tos;
    logic       reg_tos;
    logic       sel_tos_updater;
    logic       ctrl_stack;
    logic       mem_ext;
  } strobe_t;

  function automatic logic [2:0] src_of(logic [2:0] op);
    logic [2:0] s;
    unique case (op)
      OP_PUSH_ALU: s = SRC_ALU;
      OP_PUSH_MEM: s = SRC_MEM;
      OP_PUSH_RET: s = SRC_RET;
      OP_PUSH_ARG: s = SRC_ARG;
      default:     s = SRC_TOP;
    endcase
    return s;
  endfunction

  function automatic state_t first_state(logic [2:0] op);
    state_t s;
    unique case (op)
      OP_PUSH_MEM:    s = ST_MRD;
      OP_DUP, OP_POP: s = ST_SRD;
      OP_STORE:       s = ST_MW0;
      OP_SET_TOS:     s = ST_SET;
      default:        s = ST_LOAD;
    endcase
    return s;
  endfunction

  function automatic logic is_last(state_t s);
    return (s == ST_WR) || (s == ST_DEC) ||
           (s == ST_SET) || (s == ST_ERR);
  endfunction

  function automatic strobe_t decode(state_t s, logic [2:0] src);
    strobe_t o;
    o = '0;
    unique case (s)
      ST_SRD: o.read_stack = 1'b1;
      ST_MRD: o.read_mem = 1'b1;
      ST_LOAD: begin
        o.write_stack   = 1'b1;
        o.sel_mux_stack = src;
      end
      ST_INC: o.reg_tos = 1'b1;
      ST_DEC: begin
        o.reg_tos         = 1'b1;
        o.sel_tos_updater = 1'b1;
      end
      ST_WR:  o.ctrl_stack = 1'b1;
      ST_MW0: o.write_mem = 1'b1;
      ST_MW1: o.mem_ext = 1'b1;
      ST_SET: begin
        o.sel_mux_tos = 1'b1;
        o.reg_tos     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Command handshake bundle: valid/op/tos from upstream,
// ready/done/err back. master = issuer, slave = sequencer.
interface stack_op_sequencer_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic                  CMD_VALID;
  logic [2:0]            CMD_OP;
  logic [ADDR_WIDTH-1:0] CMD_TOS_VALUE;
  logic                  CMD_READY;
  logic                  CMD_DONE;
  logic                  CMD_ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_TOS_VALUE,
    input  CMD_READY, CMD_DONE, CMD_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_TOS_VALUE,
    output CMD_READY, CMD_DONE, CMD_ERR
  );
endinterface

// File: rtl/stack_op_sequencer_depth_tracker.sv
// Stack depth register (inc/dec/load) with full/empty flags.
// Ports: clk, reset (sync, active-low), inc, dec, load, load_value,
// depth, full, empty. Flags are live only with STACK_GUARD_EN.
module stack_depth_tracker #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_DEPTH  = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  full,
  output logic                  empty
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      depth <= '0;
    end else begin
      unique case (1'b1)
        load:    depth <= load_value;
        inc:     depth <= depth + 1'b1;
        dec:     depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  assign full  = (int'(depth) == MAX_DEPTH);
  assign empty = (depth == '0);
`else
  logic [ADDR_WIDTH-1:0] unused_max;
  assign unused_max = ADDR_WIDTH'(MAX_DEPTH);
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

endmodule

// File: rtl/stack_op_sequencer.sv
// Expands one stack command into a fixed strobe sequence (Moore).
// Ports: clk, reset (sync, active-low), cmd (handshake slave),
// DEPTH, datapath strobes. Optional guard: STACK_GUARD_EN.
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_DEPTH  = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_op_sequencer_if.slave   cmd,
  output logic [ADDR_WIDTH-1:0] DEPTH,
  output logic [2:0]            SEL_MUX_STACK,
  output logic                  CTRL_REG_READ_STACK,
  output logic                  CTRL_REG_WRITE_STACK,
  output logic                  CTRL_REG_READ_MEM,
  output logic                  CTRL_REG_WRITE_MEM,
  output logic                  SEL_MUX_TOS,
  output logic                  CTRL_REG_TOS,
  output logic                  SEL_TOS_UPDATER,
  output logic                  CTRL_STACK,
  output logic                  CTRL_MEM_EXT
);

  state_t                state;
  state_t                state_n;
  logic [2:0]            op_q;
  logic [2:0]            op_n;
  logic [ADDR_WIDTH-1:0] tos_q;
  strobe_t               stb;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic                  accept;
  logic                  reject;
  logic                  full;
  logic                  empty;
  logic                  push_cls;
  logic                  drain_cls;
  logic                  tos_bad;

  assign accept = cmd.CMD_VALID && ready;
  // In IDLE the incoming opcode steers; afterwards the latched one.
  assign op_n   = (state == ST_IDLE) ? cmd.CMD_OP : op_q;

  assign push_cls  = !op_n[2] || (op_n == OP_DUP);
  assign drain_cls = (op_n == OP_POP) || (op_n == OP_STORE) ||
                     (op_n == OP_DUP);

`ifdef STACK_GUARD_EN
  assign tos_bad = (op_n == OP_SET_TOS) &&
                   (int'(cmd.CMD_TOS_VALUE) > MAX_DEPTH);
`else
  assign tos_bad = 1'b0;
`endif

  assign reject = (push_cls && full) || (drain_cls && empty) ||
                  tos_bad;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = reject ? ST_ERR : first_state(cmd.CMD_OP);
        end
      end
      ST_SRD:  state_n = (op_q == OP_POP) ? ST_DEC : ST_LOAD;
      ST_MRD:  state_n = ST_LOAD;
      ST_LOAD: state_n = ST_INC;
      ST_INC:  state_n = ST_WR;
      ST_MW0:  state_n = ST_MW1;
      ST_MW1:  state_n = ST_DEC;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state register without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= OP_PUSH_ALU;
      tos_q <= '0;
      stb   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd.CMD_OP;
        tos_q <= cmd.CMD_TOS_VALUE;
      end
      state <= state_n;
      stb   <= decode(state_n, src_of(op_n));
      ready <= (state_n == ST_IDLE);
      done  <= is_last(state_n);
`ifdef STACK_GUARD_EN
      err   <= (state_n == ST_ERR);
`else
      err   <= 1'b0;
`endif
    end
  end

  stack_depth_tracker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_depth (
    .clk       (clk),
    .reset     (reset),
    .inc       (state == ST_INC),
    .dec       (state == ST_DEC),
    .load      (state == ST_SET),
    .load_value(tos_q),
    .depth     (DEPTH),
    .full      (full),
    .empty     (empty)
  );

  assign cmd.CMD_READY = ready;
  assign cmd.CMD_DONE  = done;
  assign cmd.CMD_ERR   = err;

  assign SEL_MUX_STACK        = stb.sel_mux_stack;
  assign CTRL_REG_READ_STACK  = stb.read_stack;
  assign CTRL_REG_WRITE_STACK = stb.write_stack;
  assign CTRL_REG_READ_MEM    = stb.read_mem;
  assign CTRL_REG_WRITE_MEM   = stb.write_mem;
  assign SEL_MUX_TOS          = stb.sel_mux_tos;
  assign CTRL_REG_TOS         = stb.reg_tos;
  assign SEL_TOS_UPDATER      = stb.sel_tos_updater;
  assign CTRL_STACK           = stb.ctrl_stack;
  assign CTRL_MEM_EXT         = stb.mem_ext;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer: vector table,
// hand-written corner sequences and randomized model check.
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  localparam int AW = 12;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Strobe words: {sel[2:0], rd_stk, wr_stk, rd_mem, wr_mem,
  // sel_tos, reg_tos, upd, ctrl_stack, mem_ext}
  localparam logic [11:0] W_SRD = 12'h100;
  localparam logic [11:0] W_WRS = 12'h080;
  localparam logic [11:0] W_MRD = 12'h040;
  localparam logic [11:0] W_MW0 = 12'h020;
  localparam logic [11:0] W_SET = 12'h018;
  localparam logic [11:0] W_INC = 12'h008;
  localparam logic [11:0] W_DEC = 12'h00C;
  localparam logic [11:0] W_WR  = 12'h002;
  localparam logic [11:0] W_MW1 = 12'h001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_op_sequencer_if #(.ADDR_WIDTH(AW)) cif ();

  logic [AW-1:0] depth;
  logic [2:0]    sel;
  logic rs, ws, rm, wm, smt, rtos, upd, cst, mext;

  stack_op_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd                 (cif),
    .DEPTH               (depth),
    .SEL_MUX_STACK       (sel),
    .CTRL_REG_READ_STACK (rs),
    .CTRL_REG_WRITE_STACK(ws),
    .CTRL_REG_READ_MEM   (rm),
    .CTRL_REG_WRITE_MEM  (wm),
    .SEL_MUX_TOS         (smt),
    .CTRL_REG_TOS        (rtos),
    .SEL_TOS_UPDATER     (upd),
    .CTRL_STACK          (cst),
    .CTRL_MEM_EXT        (mext)
  );

  int tests = 0;
  int fails = 0;
  int md = 0;
  logic [11:0] got[$];
  logic [11:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [11:0] tos;
    int          d_off;
    int          d_on;
    bit          e_on;
  } vec_t;

  vec_t vt[$];

  function automatic logic [11:0] strb();
    return {sel, rs, ws, rm, wm, smt, rtos, upd, cst, mext};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: expected strobe list and depth from the command rules.
  task automatic model(input logic [2:0] op, input logic [11:0] tos,
                       output bit rej);
    bit push, drain;
    push  = (op == OP_PUSH_ALU) || (op == OP_PUSH_MEM) ||
            (op == OP_PUSH_RET) || (op == OP_PUSH_ARG) ||
            (op == OP_DUP);
    drain = (op == OP_POP) || (op == OP_STORE) || (op == OP_DUP);
    rej = GUARD && ((push && md == 4095) || (drain && md == 0));
    exp_q.delete();
    if (rej) begin
      exp_q.push_back(12'h000);
      return;
    end
    case (op)
      OP_PUSH_ALU, OP_PUSH_RET, OP_PUSH_ARG: begin
        exp_q.push_back(W_WRS | {op, 9'b0});
        exp_q.push_back(W_INC);
        exp_q.push_back(W_WR);
      end
      OP_PUSH_MEM: begin
        exp_q.push_back(W_MRD);
        exp_q.push_back(W_WRS | 12'h200);
        exp_q.push_back(W_INC);
        exp_q.push_back(W_WR);
      end
      OP_DUP: begin
        exp_q.push_back(W_SRD);
        exp_q.push_back(W_WRS | 12'h800);
        exp_q.push_back(W_INC);
        exp_q.push_back(W_WR);
      end
      OP_POP: begin
        exp_q.push_back(W_SRD);
        exp_q.push_back(W_DEC);
      end
      OP_STORE: begin
        exp_q.push_back(W_MW0);
        exp_q.push_back(W_MW1);
        exp_q.push_back(W_DEC);
      end
      default: exp_q.push_back(W_SET);
    endcase
    if (push) md = (md + 1) % 4096;
    else if (op == OP_SET_TOS) md = int'(tos);
    else md = (md + 4095) % 4096;
  endtask

  task automatic run(input logic [2:0] op, input logic [11:0] tos,
                     output bit to, output bit rdy_low,
                     output bit err_early, output bit err_done);
    int n;
    bit dn;
    got.delete();
    n = 0;
    while (!cif.CMD_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    cif.CMD_VALID = 1'b1;
    cif.CMD_OP = op;
    cif.CMD_TOS_VALUE = tos;
    @(posedge clk);
    #1 cif.CMD_VALID = 1'b0;
    dn = 1'b0;
    n = 0;
    rdy_low = 1'b1;
    err_early = 1'b0;
    err_done = 1'b0;
    while (!dn && n < 10) begin
      @(negedge clk);
      n++;
      got.push_back(strb());
      if (cif.CMD_READY) rdy_low = 1'b0;
      if (cif.CMD_ERR && !cif.CMD_DONE) err_early = 1'b1;
      if (cif.CMD_DONE) begin
        dn = 1'b1;
        err_done = cif.CMD_ERR;
      end
    end
    to = !dn;
  endtask

  task automatic do_cmd(input string nm, input logic [2:0] op,
                        input logic [11:0] tos, output bit e);
    bit rej, to, rl, ee;
    model(op, tos, rej);
    run(op, tos, to, rl, ee, e);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    chk({nm, "_len"}, got.size(), exp_q.size());
    if (got.size() == exp_q.size()) begin
      for (int i = 0; i < got.size(); i++)
        chk($sformatf("%s_stb%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
    end
    chk({nm, "_ready_low"}, 32'(rl), 32'd1);
    chk({nm, "_err_early"}, 32'(ee), 32'd0);
    chk({nm, "_err"}, 32'(e), 32'(rej));
    @(negedge clk);
    chk({nm, "_depth"}, 32'(depth), 32'(md));
    chk({nm, "_ready_back"}, 32'(cif.CMD_READY), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cif.CMD_READY), 32'd1);
    chk("rst_done", 32'(cif.CMD_DONE), 32'd0);
    chk("rst_err", 32'(cif.CMD_ERR), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_stb", 32'(strb()), 32'd0);
    #1 reset = 1'b1;
    md = 0;
    @(negedge clk);
  endtask

  task automatic reset_mid();
    bit dn_any;
    int n;
    @(negedge clk);
    cif.CMD_VALID = 1'b1;
    cif.CMD_OP = OP_PUSH_MEM;
    @(posedge clk);
    #1 cif.CMD_VALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_inc_stb", 32'(strb()), 32'(W_INC));
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    md = 0;
    @(negedge clk);
    chk("mid_ready", 32'(cif.CMD_READY), 32'd1);
    chk("mid_depth", 32'(depth), 32'd0);
    chk("mid_stb", 32'(strb()), 32'd0);
    dn_any = cif.CMD_DONE;
    for (n = 0; n < 4; n++) begin
      @(negedge clk);
      dn_any = dn_any | cif.CMD_DONE;
    end
    chk("mid_no_done", 32'(dn_any), 32'd0);
  endtask

  task automatic back_to_back();
    int c;
    int loads[$];
    int dones[$];
    cif.CMD_OP = OP_PUSH_ALU;
    cif.CMD_VALID = 1'b1;
    c = 0;
    while (dones.size() < 3 && c < 40) begin
      @(negedge clk);
      c++;
      if (ws) loads.push_back(c);
      if (cif.CMD_DONE) dones.push_back(c);
      if (loads.size() == 3) cif.CMD_VALID = 1'b0;
    end
    cif.CMD_VALID = 1'b0;
    chk("b2b_loads", loads.size(), 32'd3);
    chk("b2b_dones", dones.size(), 32'd3);
    if (loads.size() == 3 && dones.size() == 3) begin
      chk("b2b_first", loads[0], 32'd1);
      chk("b2b_gap0", loads[1], dones[0] + 2);
      chk("b2b_gap1", loads[2], dones[1] + 2);
    end
    md = (md + 3) % 4096;
    @(negedge clk);
    chk("b2b_depth", 32'(depth), 32'(md));
  endtask

  initial begin
    bit e;
    logic [2:0] rop;
    logic [11:0] rtv;
    cif.CMD_VALID = 1'b0;
    cif.CMD_OP = '0;
    cif.CMD_TOS_VALUE = '0;

    vt.push_back('{OP_PUSH_ALU, 12'd0,    1,    1, 0});
    vt.push_back('{OP_POP,      12'd0,    0,    0, 0});
    vt.push_back('{OP_PUSH_ARG, 12'd0,    1,    1, 0});
    vt.push_back('{OP_PUSH_ARG, 12'd0,    2,    2, 0});
    vt.push_back('{OP_PUSH_ARG, 12'd0,    3,    3, 0});
    vt.push_back('{OP_POP,      12'd0,    2,    2, 0});
    vt.push_back('{OP_SET_TOS,  12'd1,    1,    1, 0});
    vt.push_back('{OP_DUP,      12'd0,    2,    2, 0});
    vt.push_back('{OP_STORE,    12'd0,    1,    1, 0});
    vt.push_back('{OP_PUSH_MEM, 12'd0,    2,    2, 0});
    vt.push_back('{OP_PUSH_RET, 12'd0,    3,    3, 0});
    vt.push_back('{OP_SET_TOS,  12'd0,    0,    0, 0});
    vt.push_back('{OP_POP,      12'd0, 4095,    0, 1});
    vt.push_back('{OP_STORE,    12'd0, 4094,    0, 1});
    vt.push_back('{OP_DUP,      12'd0, 4095,    0, 1});
    vt.push_back('{OP_SET_TOS,  12'd4095, 4095, 4095, 0});
    vt.push_back('{OP_PUSH_ALU, 12'd0,    0, 4095, 1});
    vt.push_back('{OP_DUP,      12'd0,    1, 4095, 1});

    do_reset();

    for (int i = 0; i < vt.size(); i++) begin
      do_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].tos, e);
      chk($sformatf("vec%0d_tbl_depth", i), 32'(depth),
          32'(GUARD ? vt[i].d_on : vt[i].d_off));
      chk($sformatf("vec%0d_tbl_err", i), 32'(e),
          32'(GUARD & vt[i].e_on));
    end

    reset_mid();
    back_to_back();

    do_reset();
    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      rtv = ($urandom_range(0, 3) == 0) ? 12'd4095 :
            12'($urandom_range(0, 6));
      do_cmd($sformatf("rnd%0d", i), rop, rtv, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
